// File: rtl/conv_sram_responder_pkg.sv
// Shared types and constants for the binary-conv SRAM responder.
// Optional read-during-write forwarding is selected by CONV_SRAM_BYPASS_EN
// (see conv_sram_responder.sv).
package conv_mem_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4096;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] word_t;

  typedef enum logic {CLEAR, SERVE} mem_state_t;

  // True when an address maps onto a physical word of a depth-word array.
  function automatic logic in_range(addr_t a, int unsigned depth);
    return 32'(a) < depth;
  endfunction

endpackage

// File: rtl/conv_sram_responder_if.sv
// Bus bundle between the conv datapath / host and the SRAM responder.
//
// Handshake semantics:
//   - DUT read port: no handshake; the address is sampled on every clock edge
//     and the word appears on sram_dut_read_data READ_LAT edges later.
//   - DUT write port: dut_sram_write_enable commits on the edge, always wins.
//   - Host port: host_req is the valid; host_gnt is the combinational ready.
//     A transfer happens on an edge where host_req && host_gnt. Reads are
//     always granted in SERVE; writes are granted only when the DUT is not
//     writing, and an ungranted host must hold its request stable.
//     host_rvalid pulses for one cycle READ_LAT edges after a granted read.
//   - ready: the post-reset clear has finished; nothing is serviced before it.
interface conv_sram_responder_if;
  import conv_mem_pkg::*;

  addr_t dut_sram_read_address;
  word_t sram_dut_read_data;
  addr_t dut_sram_write_address;
  word_t dut_sram_write_data;
  logic  dut_sram_write_enable;
  logic  host_req;
  logic  host_we;
  addr_t host_addr;
  word_t host_wdata;
  logic  host_gnt;
  logic  host_rvalid;
  word_t host_rdata;
  logic  ready;

  modport slave (
    input  dut_sram_read_address, dut_sram_write_address, dut_sram_write_data,
    input  dut_sram_write_enable, host_req, host_we, host_addr, host_wdata,
    output sram_dut_read_data, host_gnt, host_rvalid, host_rdata, ready
  );

  modport master (
    output dut_sram_read_address, dut_sram_write_address, dut_sram_write_data,
    output dut_sram_write_enable, host_req, host_we, host_addr, host_wdata,
    input  sram_dut_read_data, host_gnt, host_rvalid, host_rdata, ready
  );

endinterface

// File: rtl/conv_sram_responder_read_pipe.sv
// conv_read_pipe: LAT-deep data+valid delay line with synchronous clear.
// Stage 0 is the RAM output register; a second stage is the optional
// output register used when READ_LAT=2.
module conv_read_pipe #(
  parameter int W   = 16,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [W-1:0]   d_q [LAT];
  logic [LAT-1:0] v_q;

  // Shift data and valid one stage per cycle; clear drops everything in flight.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < LAT; i++) d_q[i] <= '0;
      v_q <= '0;
    end else begin
      d_q[0] <= in_data;
      v_q[0] <= in_valid;
      for (int i = 1; i < LAT; i++) begin
        d_q[i] <= d_q[i-1];
        v_q[i] <= v_q[i-1];
      end
    end
  end

  assign out_valid = v_q[LAT-1];
  assign out_data  = d_q[LAT-1];

endmodule

// File: rtl/conv_sram_responder.sv
// conv_sram_responder: DEPTH x DATA_W synchronous RAM serving the conv
// datapath (fixed-latency read, priority write) and a host back-door port.
// After every reset a clear engine zeroes the array before ports are served.
// Define CONV_SRAM_BYPASS_EN to forward same-cycle write data to reads;
// without it a read colliding with a write returns the old contents.
module conv_sram_responder #(
  parameter int DEPTH    = conv_mem_pkg::DEPTH,
  parameter int READ_LAT = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  conv_sram_responder_if.slave    bus,
  output conv_mem_pkg::mem_state_t state_dbg
);
  import conv_mem_pkg::*;

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  mem_state_t state;
  addr_t      clr_addr;
  logic       ready_q;

  word_t mem [DEPTH];

  logic  serving;
  logic  host_wr_gnt;
  logic  host_rd_gnt;
  logic  mem_we;
  addr_t mem_waddr;
  word_t mem_wdata;
  word_t dut_rd_word;
  word_t host_rd_word;
  logic  pipe_clr;
  logic  dut_pipe_v;
  word_t dut_pipe_d;

  assign serving     = (state == SERVE);
  assign host_wr_gnt = serving && bus.host_req && bus.host_we && !bus.dut_sram_write_enable;
  assign host_rd_gnt = serving && bus.host_req && !bus.host_we;

  // Clear FSM: one zero word per cycle from address 0 up to DEPTH-1, then serve.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= CLEAR;
      clr_addr <= '0;
      ready_q  <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == addr_t'(DEPTH - 1)) begin
            state   <= SERVE;
            ready_q <= 1'b1;
          end
        end
        SERVE:   ready_q <= 1'b1;
        default: state   <= CLEAR;
      endcase
    end
  end

  // Single write port: clear engine, else DUT, else granted host; out-of-range dropped.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = clr_addr;
    mem_wdata = '0;
    if (!reset) begin
      if (state == CLEAR) begin
        mem_we = 1'b1;
      end else if (bus.dut_sram_write_enable) begin
        mem_waddr = bus.dut_sram_write_address;
        mem_wdata = bus.dut_sram_write_data;
        mem_we    = in_range(bus.dut_sram_write_address, DEPTH);
      end else if (host_wr_gnt) begin
        mem_waddr = bus.host_addr;
        mem_wdata = bus.host_wdata;
        mem_we    = in_range(bus.host_addr, DEPTH);
      end
    end
  end

  // Array write; no reset on the storage itself, the clear engine zeroes it.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr[IDX_W-1:0]] <= mem_wdata;
  end

  // Read words ahead of the latency pipe; out-of-range reads yield zero.
  always_comb begin
    dut_rd_word  = '0;
    host_rd_word = '0;
    if (in_range(bus.dut_sram_read_address, DEPTH))
      dut_rd_word = mem[bus.dut_sram_read_address[IDX_W-1:0]];
    if (in_range(bus.host_addr, DEPTH))
      host_rd_word = mem[bus.host_addr[IDX_W-1:0]];
`ifdef CONV_SRAM_BYPASS_EN
    // mem_we implies an in-range address, so a hit also implies an in-range read.
    if (serving && mem_we && (mem_waddr == bus.dut_sram_read_address))
      dut_rd_word = mem_wdata;
    if (serving && mem_we && (mem_waddr == bus.host_addr))
      host_rd_word = mem_wdata;
`endif
  end

  // Pipes are held cleared until SERVE so read outputs stay zero during clear.
  assign pipe_clr = reset || !serving;

  conv_read_pipe #(.W(DATA_W), .LAT(READ_LAT)) u_dut_pipe (
    .clk       (clk),
    .clr       (pipe_clr),
    .in_valid  (1'b1),
    .in_data   (dut_rd_word),
    .out_valid (dut_pipe_v),
    .out_data  (dut_pipe_d)
  );

  conv_read_pipe #(.W(DATA_W), .LAT(READ_LAT)) u_host_pipe (
    .clk       (clk),
    .clr       (pipe_clr),
    .in_valid  (host_rd_gnt),
    .in_data   (host_rd_word),
    .out_valid (bus.host_rvalid),
    .out_data  (bus.host_rdata)
  );

  assign bus.sram_dut_read_data = dut_pipe_v ? dut_pipe_d : '0;
  assign bus.host_gnt           = host_rd_gnt || host_wr_gnt;
  assign bus.ready              = ready_q;
  assign state_dbg              = state;

endmodule

// File: tb/tb_conv_sram_responder.sv
// Bench for conv_sram_responder: a 4096-word READ_LAT=1 instance for the
// main scenarios and a 2048-word READ_LAT=2 instance for the out-of-range
// and second-latency cases. Expected values come from a word-array model.
module tb_conv_sram_responder;
  import conv_mem_pkg::*;

  localparam int RL  = 1;
  localparam int RL2 = 2;
  localparam int D1  = 4096;
  localparam int D2  = 2048;
`ifdef CONV_SRAM_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_state_t state1, state2;
  int n_checks = 0;
  int n_fail   = 0;

  word_t model_mem [D1];
  word_t exp_q[$];
  word_t host_d_q[$];
  logic  host_v_q[$];

  conv_sram_responder_if bus1 ();
  conv_sram_responder_if bus2 ();

  conv_sram_responder #(.DEPTH(D1), .READ_LAT(RL)) u_dut (
    .clk(clk), .reset(reset), .bus(bus1.slave), .state_dbg(state1));

  conv_sram_responder #(.DEPTH(D2), .READ_LAT(RL2)) u_dut_oor (
    .clk(clk), .reset(reset), .bus(bus2.slave), .state_dbg(state2));

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic idle_all();
    bus1.dut_sram_read_address = '0; bus1.dut_sram_write_address = '0;
    bus1.dut_sram_write_data = '0;   bus1.dut_sram_write_enable = 1'b0;
    bus1.host_req = 1'b0; bus1.host_we = 1'b0; bus1.host_addr = '0; bus1.host_wdata = '0;
    bus2.dut_sram_read_address = '0; bus2.dut_sram_write_address = '0;
    bus2.dut_sram_write_data = '0;   bus2.dut_sram_write_enable = 1'b0;
    bus2.host_req = 1'b0; bus2.host_we = 1'b0; bus2.host_addr = '0; bus2.host_wdata = '0;
  endtask

  // Leaves the bench at the first negedge after the reset edge.
  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  // Counts negedges with ready low on each instance, bounded.
  task automatic wait_ready(output int c1, output int c2);
    c1 = 0; c2 = 0;
    for (int i = 0; i < 6000; i++) begin
      if (bus1.ready === 1'b1 && bus2.ready === 1'b1) break;
      if (bus1.ready !== 1'b1) c1++;
      if (bus2.ready !== 1'b1) c2++;
      @(negedge clk);
    end
  endtask

  task automatic host_write1(input addr_t a, input word_t d, output bit granted);
    @(negedge clk);
    bus1.host_req = 1'b1; bus1.host_we = 1'b1; bus1.host_addr = a; bus1.host_wdata = d;
    granted = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (bus1.host_gnt === 1'b1) begin granted = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    bus1.host_req = 1'b0; bus1.host_we = 1'b0;
  endtask

  task automatic host_read1(input addr_t a, output word_t d, output logic v);
    @(negedge clk);
    bus1.host_req = 1'b1; bus1.host_we = 1'b0; bus1.host_addr = a;
    @(negedge clk);
    bus1.host_req = 1'b0;
    repeat (RL - 1) @(negedge clk);
    v = bus1.host_rvalid; d = bus1.host_rdata;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int c1, c2;
    word_t d; logic v;
    addr_t probe [3];
    probe[0] = 12'h000; probe[1] = 12'h7FF; probe[2] = 12'hFFF;
    do_reset();
    n_checks++; if (bus1.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", bus1.ready); end
    n_checks++; if (bus1.sram_dut_read_data !== 16'h0) begin n_fail++; $display("FAIL reset_dut_rdata: got %h expected 0000", bus1.sram_dut_read_data); end
    n_checks++; if (bus1.host_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 0", bus1.host_rvalid); end
    n_checks++; if (bus1.host_rdata !== 16'h0) begin n_fail++; $display("FAIL reset_host_rdata: got %h expected 0000", bus1.host_rdata); end
    n_checks++; if (state1 !== CLEAR) begin n_fail++; $display("FAIL reset_state: got %0d expected CLEAR", state1); end
    wait_ready(c1, c2);
    n_checks++; if (c1 !== D1) begin n_fail++; $display("FAIL clear_time: got %0d cycles expected %0d", c1, D1); end
    n_checks++; if (c2 !== D2) begin n_fail++; $display("FAIL clear_time_d2: got %0d cycles expected %0d", c2, D2); end
    for (int i = 0; i < 3; i++) begin
      host_read1(probe[i], d, v);
      n_checks++; if (v !== 1'b1 || d !== 16'h0) begin n_fail++; $display("FAIL clear_read[%h]: got v=%b d=%h expected v=1 d=0000", probe[i], v, d); end
    end
  endtask

  task automatic test_host_load_dut_read();
    bit g;
    host_write1(12'h010, 16'h5A3C, g);
    n_checks++; if (g !== 1'b1) begin n_fail++; $display("FAIL load_gnt: got %b expected 1", g); end
    bus1.dut_sram_read_address = 12'h010;
    repeat (RL) @(negedge clk);
    n_checks++; if (bus1.sram_dut_read_data !== 16'h5A3C) begin n_fail++; $display("FAIL load_dut_read: got %h expected 5a3c", bus1.sram_dut_read_data); end
  endtask

  task automatic test_write_arbitration();
    word_t d; logic v;
    @(negedge clk);
    bus1.dut_sram_write_enable = 1'b1; bus1.dut_sram_write_address = 12'h020; bus1.dut_sram_write_data = 16'h000F;
    bus1.host_req = 1'b1; bus1.host_we = 1'b1; bus1.host_addr = 12'h020; bus1.host_wdata = 16'hFFFF;
    #1;
    n_checks++; if (bus1.host_gnt !== 1'b0) begin n_fail++; $display("FAIL arb_blocked_gnt: got %b expected 0", bus1.host_gnt); end
    @(negedge clk);
    bus1.dut_sram_write_enable = 1'b0;
    #1;
    n_checks++; if (bus1.host_gnt !== 1'b1) begin n_fail++; $display("FAIL arb_retry_gnt: got %b expected 1", bus1.host_gnt); end
    @(negedge clk);
    bus1.host_req = 1'b0; bus1.host_we = 1'b0;
    host_read1(12'h020, d, v);
    n_checks++; if (v !== 1'b1 || d !== 16'hFFFF) begin n_fail++; $display("FAIL arb_final_read: got v=%b d=%h expected v=1 d=ffff", v, d); end
  endtask

  task automatic test_read_during_write();
    bit g;
    word_t e;
    host_write1(12'h030, 16'h1111, g);
    bus1.dut_sram_write_enable = 1'b1; bus1.dut_sram_write_address = 12'h030;
    bus1.dut_sram_write_data = 16'h2222; bus1.dut_sram_read_address = 12'h030;
    @(negedge clk);
    bus1.dut_sram_write_enable = 1'b0;
    e = BYPASS ? 16'h2222 : 16'h1111;
    n_checks++; if (bus1.sram_dut_read_data !== e) begin n_fail++; $display("FAIL rdw_same_cycle: got %h expected %h", bus1.sram_dut_read_data, e); end
    @(negedge clk);
    n_checks++; if (bus1.sram_dut_read_data !== 16'h2222) begin n_fail++; $display("FAIL rdw_next_cycle: got %h expected 2222", bus1.sram_dut_read_data); end
  endtask

  task automatic test_reset_mid_op();
    int c1, c2;
    int bad_gnt, bad_out;
    bit saw_valid;
    do_reset();
    bad_gnt = 0; bad_out = 0;
    // Traffic during clear must be ignored.
    for (int i = 0; i < 100; i++) begin
      if (bus1.host_rvalid !== 1'b0 || bus1.sram_dut_read_data !== 16'h0) bad_out++;
      bus1.host_req = 1'b1; bus1.host_we = 1'($urandom_range(0, 1));
      bus1.host_addr = addr_t'($urandom_range(0, 4095)); bus1.host_wdata = word_t'($urandom);
      bus1.dut_sram_write_enable = 1'b1; bus1.dut_sram_write_data = word_t'($urandom | 1);
      bus1.dut_sram_write_address = addr_t'($urandom_range(0, 4095));
      bus1.dut_sram_read_address = addr_t'($urandom_range(0, 4095));
      #1;
      if (bus1.host_gnt !== 1'b0) bad_gnt++;
      @(negedge clk);
    end
    n_checks++; if (bad_gnt != 0) begin n_fail++; $display("FAIL clear_gnt: got %0d granted cycles expected 0", bad_gnt); end
    n_checks++; if (bad_out != 0) begin n_fail++; $display("FAIL clear_outputs: got %0d nonzero cycles expected 0", bad_out); end
    idle_all();
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    wait_ready(c1, c2);
    n_checks++; if (c1 !== D1) begin n_fail++; $display("FAIL midclear_reset_time: got %0d expected %0d", c1, D1); end
    // Host read issued in the same cycle as reset must never return.
    @(negedge clk);
    bus1.host_req = 1'b1; bus1.host_we = 1'b0; bus1.host_addr = 12'h010; reset = 1'b1;
    @(negedge clk);
    bus1.host_req = 1'b0; reset = 1'b0;
    saw_valid = (bus1.host_rvalid === 1'b1);
    wait_ready(c1, c2);
    n_checks++; if (saw_valid) begin n_fail++; $display("FAIL serve_reset_rvalid: got 1 expected 0"); end
    n_checks++; if (c1 !== D1) begin n_fail++; $display("FAIL serve_reset_time: got %0d expected %0d", c1, D1); end
    for (int i = 0; i < D1; i++) model_mem[i] = '0;
  endtask

  task automatic test_random();
    word_t e, ed, rd, wd;
    logic ev;
    addr_t ra, wa, ha;
    bit dwe, hreq, hwe, wr, active, exp_gnt;
    exp_q.delete(); host_d_q.delete(); host_v_q.delete();
    for (int cyc = 0; cyc < 400 + RL; cyc++) begin
      @(negedge clk);
      if (exp_q.size() == RL) begin
        e  = exp_q.pop_front();
        ev = host_v_q.pop_front();
        ed = host_d_q.pop_front();
        n_checks++; if (bus1.sram_dut_read_data !== e) begin n_fail++; $display("FAIL rand_dut_read[%0d]: got %h expected %h", cyc, bus1.sram_dut_read_data, e); end
        n_checks++; if (bus1.host_rvalid !== ev) begin n_fail++; $display("FAIL rand_rvalid[%0d]: got %b expected %b", cyc, bus1.host_rvalid, ev); end
        if (ev) begin
          n_checks++; if (bus1.host_rdata !== ed) begin n_fail++; $display("FAIL rand_host_read[%0d]: got %h expected %h", cyc, bus1.host_rdata, ed); end
        end
      end
      active = (cyc < 400);
      ra   = ($urandom_range(0, 7) == 0) ? addr_t'($urandom_range(0, 4095)) : addr_t'($urandom_range(0, 15));
      wa   = addr_t'($urandom_range(0, 15));
      ha   = addr_t'($urandom_range(0, 15));
      dwe  = active && ($urandom_range(0, 2) == 0);
      hreq = active && ($urandom_range(0, 1) == 0);
      hwe  = 1'($urandom_range(0, 1));
      wd   = word_t'($urandom);
      bus1.dut_sram_read_address = ra;
      bus1.dut_sram_write_enable = dwe; bus1.dut_sram_write_address = wa; bus1.dut_sram_write_data = wd;
      bus1.host_req = hreq; bus1.host_we = hwe; bus1.host_addr = ha; bus1.host_wdata = ~wd;
      #1;
      exp_gnt = hreq && (!hwe || !dwe);
      n_checks++; if (bus1.host_gnt !== exp_gnt) begin n_fail++; $display("FAIL rand_gnt[%0d]: got %b expected %b", cyc, bus1.host_gnt, exp_gnt); end
      // Model: reads see the array before this edge's write (or the new word with forwarding).
      wr = 1'b0;
      if (dwe) wr = 1'b1;
      else if (hreq && hwe) begin wr = 1'b1; wa = ha; wd = ~wd; end
      rd = model_mem[ra];
      if (BYPASS && wr && wa == ra) rd = wd;
      exp_q.push_back(rd);
      rd = model_mem[ha];
      if (BYPASS && wr && wa == ha) rd = wd;
      host_d_q.push_back(rd);
      host_v_q.push_back(hreq && !hwe);
      if (wr) model_mem[wa] = wd;
    end
    idle_all();
  endtask

  task automatic test_out_of_range();
    bit saw_valid;
    // In-range word whose low address bits alias 0x900 in a 2048-word array.
    @(negedge clk);
    bus2.host_req = 1'b1; bus2.host_we = 1'b1; bus2.host_addr = 12'h100; bus2.host_wdata = 16'h1234;
    @(negedge clk);
    bus2.host_addr = 12'h900; bus2.host_wdata = 16'hBEEF;
    #1;
    n_checks++; if (bus2.host_gnt !== 1'b1) begin n_fail++; $display("FAIL oor_write_gnt: got %b expected 1", bus2.host_gnt); end
    @(negedge clk);
    bus2.host_we = 1'b0; bus2.host_addr = 12'h900;
    bus2.dut_sram_read_address = 12'h900;
    @(negedge clk);
    bus2.host_addr = 12'h100;
    n_checks++; if (bus2.host_rvalid !== 1'b0) begin n_fail++; $display("FAIL lat2_early_rvalid: got %b expected 0", bus2.host_rvalid); end
    @(negedge clk);
    bus2.host_req = 1'b0;
    n_checks++; if (bus2.host_rvalid !== 1'b1 || bus2.host_rdata !== 16'h0) begin n_fail++; $display("FAIL oor_read: got v=%b d=%h expected v=1 d=0000", bus2.host_rvalid, bus2.host_rdata); end
    n_checks++; if (bus2.sram_dut_read_data !== 16'h0) begin n_fail++; $display("FAIL oor_dut_read: got %h expected 0000", bus2.sram_dut_read_data); end
    @(negedge clk);
    n_checks++; if (bus2.host_rvalid !== 1'b1 || bus2.host_rdata !== 16'h1234) begin n_fail++; $display("FAIL oor_no_alias: got v=%b d=%h expected v=1 d=1234", bus2.host_rvalid, bus2.host_rdata); end
    @(negedge clk);
    n_checks++; if (bus2.host_rvalid !== 1'b0) begin n_fail++; $display("FAIL lat2_pulse_width: got %b expected 0", bus2.host_rvalid); end
    // Reset while a READ_LAT=2 read sits in the first pipe stage.
    bus2.host_req = 1'b1; bus2.host_we = 1'b0; bus2.host_addr = 12'h100;
    @(negedge clk);
    bus2.host_req = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    saw_valid = (bus2.host_rvalid === 1'b1);
    @(negedge clk);
    saw_valid = saw_valid || (bus2.host_rvalid === 1'b1);
    n_checks++; if (saw_valid) begin n_fail++; $display("FAIL lat2_inflight_reset: got rvalid=1 expected 0"); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_all();
    for (int i = 0; i < D1; i++) model_mem[i] = '0;
    test_reset();
    test_host_load_dut_read();
    test_write_arbitration();
    test_read_during_write();
    test_reset_mid_op();
    test_random();
    test_out_of_range();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
